// File: rtl/ball_speed_ctrl.sv
// ball_speed_ctrl: ball-step tick scheduler for the Breakout core.
// Sequences IDLE -> SERVE -> RUN (with PAUSED freezing SERVE/RUN), owns the
// interval counter and shortens the tick period as bricks are broken.
// Optional feature macro: BALL_SPEEDUP_EN (brick-hit speed-up). When it is
// undefined, brick_hit is ignored and the period stays at BASE_PERIOD.
module ball_speed_ctrl #(
   parameter int BASE_PERIOD   = 250_000,
   parameter int MIN_PERIOD    = 100_000,
   parameter int STEP          = 25_000,
   parameter int HITS_PER_STEP = 4,
   parameter int SERVE_DELAY   = 60
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        pause,
   input  logic        brick_hit,
   input  logic        ball_lost,
   output logic        tick,
   output logic [1:0]  state,
   output logic [30:0] period,
   output logic [3:0]  speed_level,
   output logic        serving
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SERVE  = 2'd1,
      S_RUN    = 2'd2,
      S_PAUSED = 2'd3
   } state_t;

   localparam int SW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_DELAY - 1);
   localparam logic [30:0]   BASE_P     = 31'(BASE_PERIOD);

   state_t        r_state;
   state_t        r_ret_state;
   logic [30:0]   r_cnt;
   logic [30:0]   r_period;
   logic [SW-1:0] r_serve_cnt;

   logic          w_boundary;
   logic [30:0]   w_target;

   // Last cycle of the current interval.
   assign w_boundary = (r_cnt == r_period - 31'd1);

   // The tick is suppressed whenever a higher-priority event owns this edge,
   // because that event also holds the counter, so the boundary is replayed
   // (and ticked) later instead of being lost or doubled.
   assign tick    = (r_state == S_RUN) && w_boundary && !stop && !ball_lost && !pause;
   assign state   = r_state;
   assign period  = r_period;
   assign serving = (r_state == S_SERVE);

`ifdef BALL_SPEEDUP_EN
   localparam int HW = $clog2(HITS_PER_STEP + 1);
   localparam logic [HW-1:0] HITS_LAST = HW'(HITS_PER_STEP - 1);
   localparam logic [30:0]   MIN_P     = 31'(MIN_PERIOD);
   localparam logic [30:0]   STEP_P    = 31'(STEP);

   logic [30:0]   r_target;
   logic [3:0]    r_speed;
   logic [HW-1:0] r_hit_cnt;

   assign w_target    = r_target;
   assign speed_level = r_speed;

   // Brick-hit accounting: every HITS_PER_STEP hits in RUN shorten the next
   // period by STEP, clamped at MIN_PERIOD without underflow.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_target  <= BASE_P;
         r_speed   <= 4'd0;
         r_hit_cnt <= '0;
      end else if (stop || ((r_state == S_IDLE) && start) ||
                   ((r_state == S_RUN) && ball_lost)) begin
         r_target  <= BASE_P;
         r_speed   <= 4'd0;
         r_hit_cnt <= '0;
      end else if ((r_state == S_RUN) && !pause && brick_hit) begin
         if (r_hit_cnt == HITS_LAST) begin
            r_hit_cnt <= '0;
            if (r_target > MIN_P) begin
               r_target <= ((r_target - MIN_P) > STEP_P) ? (r_target - STEP_P) : MIN_P;
               if (r_speed != 4'd15) begin
                  r_speed <= r_speed + 4'd1;
               end
            end
         end else begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
         end
      end
   end
`else
   logic w_unused_cfg;

   assign w_target     = BASE_P;
   assign speed_level  = 4'd0;
   assign w_unused_cfg = brick_hit & (MIN_PERIOD != 0) & (STEP != 0) & (HITS_PER_STEP != 0);
`endif

   // Phase FSM with the interval and serve counters; events are resolved in
   // priority order stop > ball_lost > pause > boundary.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ret_state <= S_IDLE;
         r_cnt       <= 31'd0;
         r_period    <= BASE_P;
         r_serve_cnt <= '0;
      end else if (stop) begin
         r_state     <= S_IDLE;
         r_ret_state <= S_IDLE;
         r_cnt       <= 31'd0;
         r_period    <= BASE_P;
         r_serve_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= 31'd0;
               if (start) begin
                  r_state     <= S_SERVE;
                  r_period    <= BASE_P;
                  r_serve_cnt <= '0;
               end
            end
            S_SERVE, S_RUN: begin
               if ((r_state == S_RUN) && ball_lost) begin
                  r_state     <= S_SERVE;
                  r_cnt       <= 31'd0;
                  r_period    <= BASE_P;
                  r_serve_cnt <= '0;
               end else if (pause) begin
                  // Counters are left untouched so the interval resumes intact.
                  r_ret_state <= r_state;
                  r_state     <= S_PAUSED;
               end else if (w_boundary) begin
                  r_cnt <= 31'd0;
                  if (r_state == S_SERVE) begin
                     if (r_serve_cnt == SERVE_LAST) begin
                        r_state     <= S_RUN;
                        r_serve_cnt <= '0;
                     end else begin
                        r_serve_cnt <= r_serve_cnt + 1'b1;
                     end
                  end else begin
                     // A new period only takes effect at a boundary, never mid-interval.
                     r_period <= w_target;
                  end
               end else begin
                  r_cnt <= r_cnt + 31'd1;
               end
            end
            default: begin
               if (!pause) begin
                  r_state <= r_ret_state;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ball_speed_ctrl.sv
// Self-checking bench for ball_speed_ctrl with small periods
// (BASE=10, MIN=4, STEP=3, HITS=2, SERVE_DELAY=2). Expectations follow the
// BALL_SPEEDUP_EN setting of the build.
module tb_ball_speed_ctrl;

   localparam int BASE = 10;
   localparam int MINP = 4;
   localparam int STP  = 3;
   localparam int HPS  = 2;
   localparam int SD   = 2;
`ifdef BALL_SPEEDUP_EN
   localparam bit SPEEDUP = 1'b1;
`else
   localparam bit SPEEDUP = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        start;
   logic        stop;
   logic        pause;
   logic        brick_hit;
   logic        ball_lost;
   logic        tick;
   logic [1:0]  state;
   logic [30:0] period;
   logic [3:0]  speed_level;
   logic        serving;

   int checks   = 0;
   int failures = 0;

   ball_speed_ctrl #(
      .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .STEP(STP),
      .HITS_PER_STEP(HPS), .SERVE_DELAY(SD)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .brick_hit(brick_hit), .ball_lost(ball_lost), .tick(tick), .state(state),
      .period(period), .speed_level(speed_level), .serving(serving)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Cursor convention: tasks start and end 1 time unit after a rising edge.
   // Inputs are set there; tick is sampled at the following falling edge.
   task automatic run_cycle(output logic t_o);
      @(negedge clock);
      t_o = tick;
      @(posedge clock);
      #1;
   endtask

   // Runs until a tick is seen; n is the number of cycles consumed including
   // the tick cycle (capped at 200 on timeout).
   task automatic wait_tick(output int n);
      logic t;
      n = 0;
      do begin
         run_cycle(t);
         n++;
      end while (!t && n < 200);
   endtask

   task automatic hit_pair();
      logic t;
      brick_hit = 1'b1; run_cycle(t);
      brick_hit = 1'b0; run_cycle(t);
      brick_hit = 1'b1; run_cycle(t);
      brick_hit = 1'b0;
   endtask

   // ---------------- reference model ----------------
   int m_state, m_ret, m_elapsed, m_period, m_target, m_speed, m_hits, m_serves;

   task automatic model_clear();
      m_elapsed = 0; m_period = BASE; m_target = BASE;
      m_speed = 0; m_hits = 0; m_serves = 0;
   endtask

   task automatic model_reset();
      model_clear();
      m_state = 0; m_ret = 0;
   endtask

   function automatic bit model_tick();
      return (m_state == 2) && (m_elapsed == m_period - 1) && !stop && !ball_lost && !pause;
   endfunction

   task automatic model_clock();
      bit boundary;
      int old_target;
      boundary   = (m_elapsed == m_period - 1);
      old_target = m_target;
      if (stop) model_reset();
      else if (m_state == 0) begin
         if (start) begin model_clear(); m_state = 1; end
      end else if (m_state == 3) begin
         if (!pause) m_state = m_ret;
      end else if (m_state == 2 && ball_lost) begin
         model_clear(); m_state = 1;
      end else if (pause) begin
         m_ret = m_state; m_state = 3;
      end else begin
         if (m_state == 2 && brick_hit && SPEEDUP) begin
            m_hits++;
            if (m_hits == HPS) begin
               m_hits = 0;
               if (m_target > MINP) begin
                  m_target = (m_target - STP < MINP) ? MINP : m_target - STP;
                  if (m_speed < 15) m_speed++;
               end
            end
         end
         if (boundary) begin
            m_elapsed = 0;
            if (m_state == 1) begin
               m_serves++;
               if (m_serves == SD) begin m_state = 2; m_serves = 0; end
            end else m_period = old_target;
         end else m_elapsed++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      brick_hit = 1'b0; ball_lost = 1'b0;
      #2 reset = 1'b1;
      #2;
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b exp=0", tick); end
      checks++; if (period !== 31'(BASE)) begin failures++; $display("FAIL reset_period got=%0d exp=%0d", period, BASE); end
      checks++; if (speed_level !== 4'd0) begin failures++; $display("FAIL reset_speed got=%0d exp=0", speed_level); end
      checks++; if (serving !== 1'b0) begin failures++; $display("FAIL reset_serving got=%0b exp=0", serving); end
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_start_serve();
      logic t;
      int n, ticks;
      start = 1'b1; run_cycle(t); start = 1'b0;
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
      n = 0; ticks = 0;
      while (serving && n < 100) begin run_cycle(t); if (t) ticks++; n++; end
      checks++; if (n != SD * BASE) begin failures++; $display("FAIL serve_len got=%0d exp=%0d", n, SD * BASE); end
      checks++; if (ticks != 0) begin failures++; $display("FAIL serve_ticks got=%0d exp=0", ticks); end
      checks++; if (state !== 2'd2) begin failures++; $display("FAIL run_state got=%0d exp=2", state); end
      wait_tick(n);
      checks++; if (n != BASE) begin failures++; $display("FAIL first_tick got=%0d exp=%0d", n, BASE); end
      wait_tick(n);
      checks++; if (n != BASE) begin failures++; $display("FAIL second_tick got=%0d exp=%0d", n, BASE); end
   endtask

   task automatic test_pause();
      logic t;
      int n, ticks, bad_state;
      ticks = 0;
      for (int i = 0; i < 5; i++) begin run_cycle(t); if (t) ticks++; end
      // Interval counter is now at 5.
      pause = 1'b1; bad_state = 0;
      for (int i = 0; i < 21; i++) begin
         run_cycle(t); if (t) ticks++;
         if (state !== 2'd3) bad_state++;
      end
      checks++; if (ticks != 0) begin failures++; $display("FAIL pause_ticks got=%0d exp=0", ticks); end
      checks++; if (bad_state != 0) begin failures++; $display("FAIL pause_state not_paused_cycles=%0d exp=0", bad_state); end
      pause = 1'b0; run_cycle(t);
      checks++; if (state !== 2'd2) begin failures++; $display("FAIL resume_state got=%0d exp=2", state); end
      // Remaining counts 5..9: tick on the 5th resumed cycle.
      wait_tick(n);
      checks++; if (n != 5) begin failures++; $display("FAIL resume_tick got=%0d exp=5", n); end
   endtask

   task automatic test_speedup();
      int n;
      int exp_speed[3];
      int exp_period[3];
      exp_speed  = SPEEDUP ? '{1, 2, 2} : '{0, 0, 0};
      exp_period = SPEEDUP ? '{7, 4, 4} : '{10, 10, 10};
      for (int r = 0; r < 3; r++) begin
         int prev_period;
         prev_period = int'(period);
         hit_pair();
         checks++; if (speed_level !== 4'(exp_speed[r])) begin failures++; $display("FAIL speed_r%0d got=%0d exp=%0d", r, speed_level, exp_speed[r]); end
         checks++; if (int'(period) != prev_period) begin failures++; $display("FAIL period_hold_r%0d got=%0d exp=%0d", r, period, prev_period); end
         wait_tick(n);
         checks++; if (period !== 31'(exp_period[r])) begin failures++; $display("FAIL period_r%0d got=%0d exp=%0d", r, period, exp_period[r]); end
      end
   endtask

   task automatic test_simultaneous();
      logic t;
      int n;
      brick_hit = 1'b1; run_cycle(t);
      ball_lost = 1'b1; run_cycle(t);
      checks++; if (t !== 1'b0) begin failures++; $display("FAIL lost_tick got=%0b exp=0", t); end
      brick_hit = 1'b0; ball_lost = 1'b0;
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL lost_state got=%0d exp=1", state); end
      checks++; if (period !== 31'(BASE)) begin failures++; $display("FAIL lost_period got=%0d exp=%0d", period, BASE); end
      checks++; if (speed_level !== 4'd0) begin failures++; $display("FAIL lost_speed got=%0d exp=0", speed_level); end
      checks++; if (serving !== 1'b1) begin failures++; $display("FAIL lost_serving got=%0b exp=1", serving); end
      n = 0;
      while (state !== 2'd2 && n < 100) begin run_cycle(t); n++; end
      checks++; if (n != SD * BASE) begin failures++; $display("FAIL reserve_len got=%0d exp=%0d", n, SD * BASE); end
      // A single hit must not step the speed if the hit counter was cleared.
      brick_hit = 1'b1; run_cycle(t); brick_hit = 1'b0; run_cycle(t);
      checks++; if (speed_level !== 4'd0) begin failures++; $display("FAIL hitcnt_clear got=%0d exp=0", speed_level); end
      brick_hit = 1'b1; run_cycle(t); brick_hit = 1'b0;
      checks++; if (speed_level !== (SPEEDUP ? 4'd1 : 4'd0)) begin failures++; $display("FAIL hit_after_lost got=%0d exp=%0d", speed_level, SPEEDUP ? 1 : 0); end
   endtask

   task automatic test_async_reset();
      logic t;
      int n, ticks, bad_state;
      run_cycle(t); run_cycle(t);
      #2 reset = 1'b1;
      #1;
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL areset_state got=%0d exp=0", state); end
      checks++; if (tick !== 1'b0) begin failures++; $display("FAIL areset_tick got=%0b exp=0", tick); end
      checks++; if (period !== 31'(BASE)) begin failures++; $display("FAIL areset_period got=%0d exp=%0d", period, BASE); end
      checks++; if (speed_level !== 4'd0) begin failures++; $display("FAIL areset_speed got=%0d exp=0", speed_level); end
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
      ticks = 0; bad_state = 0;
      for (int i = 0; i < 40; i++) begin
         run_cycle(t); if (t) ticks++;
         if (state !== 2'd0) bad_state++;
      end
      checks++; if (ticks != 0 || bad_state != 0) begin failures++; $display("FAIL idle_after_reset ticks=%0d non_idle=%0d exp=0/0", ticks, bad_state); end
      start = 1'b1; run_cycle(t); start = 1'b0;
      wait_tick(n);
      checks++; if (n != SD * BASE + BASE) begin failures++; $display("FAIL restart_tick got=%0d exp=%0d", n, SD * BASE + BASE); end
   endtask

   task automatic test_random();
      logic t;
      reset = 1'b1; #2; @(posedge clock); #1; reset = 1'b0;
      start = 0; stop = 0; pause = 0; brick_hit = 0; ball_lost = 0;
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         start     = ($urandom_range(0, 14) == 0);
         stop      = ($urandom_range(0, 399) == 0);
         ball_lost = ($urandom_range(0, 99) == 0);
         brick_hit = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 24) == 0) pause = ~pause;
         @(negedge clock);
         t = tick;
         checks++; if (t !== model_tick()) begin failures++; $display("FAIL rnd_tick cyc=%0d got=%0b exp=%0b", i, t, model_tick()); end
         checks++; if (state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, state, m_state); end
         checks++; if (period !== 31'(m_period)) begin failures++; $display("FAIL rnd_period cyc=%0d got=%0d exp=%0d", i, period, m_period); end
         checks++; if (speed_level !== 4'(m_speed)) begin failures++; $display("FAIL rnd_speed cyc=%0d got=%0d exp=%0d", i, speed_level, m_speed); end
         checks++; if (serving !== (m_state == 1)) begin failures++; $display("FAIL rnd_serving cyc=%0d got=%0b exp=%0b", i, serving, m_state == 1); end
         @(posedge clock);
         model_clock();
         #1;
      end
      start = 0; stop = 0; pause = 0; brick_hit = 0; ball_lost = 0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_start_serve();
      test_pause();
      test_speedup();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
